// File: rtl/note_judge_engine_if.sv
// Port bundle for note_judge_engine: load/step/key controls in, track state and scoring out.
interface note_judge_engine_if #(
    parameter int unsigned LANES     = 3,
    parameter int unsigned TRACK_LEN = 27,
    parameter int unsigned SCORE_W   = 8,
    parameter int unsigned COMBO_W   = 8
);
    logic                         load;
    logic [LANES*TRACK_LEN-1:0]   load_notes;
    logic                         step;
    logic [LANES-1:0]             keys;
    logic [LANES*TRACK_LEN-1:0]   tracks;
    logic [LANES-1:0]             hit_zone;
    logic [SCORE_W-1:0]           score;
    logic [COMBO_W-1:0]           combo;
    logic [COMBO_W-1:0]           max_combo;
    logic                         hit_pulse;
    logic                         miss_pulse;
    logic                         playing;
    logic                         done;

    modport master (
        output load, load_notes, step, keys,
        input  tracks, hit_zone, score, combo, max_combo, hit_pulse, miss_pulse, playing, done
    );

    modport slave (
        input  load, load_notes, step, keys,
        output tracks, hit_zone, score, combo, max_combo, hit_pulse, miss_pulse, playing, done
    );
endinterface

// File: rtl/note_judge_engine.sv
// Multi-lane scrolling note tracks with hit-window judging, saturating score and combo tracking.
module note_judge_engine #(
    parameter int unsigned LANES     = 3,
    parameter int unsigned TRACK_LEN = 27,
    parameter int unsigned WINDOW    = 1,
    parameter int unsigned SCORE_W   = 8,
    parameter int unsigned COMBO_W   = 8
) (
    input logic              clk,
    input logic              reset,
    note_judge_engine_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(LANES + 1);
    localparam int unsigned SUM_W  = SCORE_W + 2;
    localparam int unsigned WIN_LO = TRACK_LEN - WINDOW;

    typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

    state_e state_q, state_d;

    logic [LANES-1:0][TRACK_LEN-1:0] tracks_q, tracks_d, cleared, shifted;
    logic [SCORE_W-1:0]              score_q, score_d;
    logic [COMBO_W-1:0]              combo_q, combo_d, max_combo_q, max_combo_d;
    logic [LANES-1:0]                keys_q, press, hit, bad, exit_miss, zone;
    logic                            hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;
    logic [CNT_W-1:0]                hit_cnt, bad_cnt;
    logic signed [SUM_W-1:0]         score_sum;
    logic [COMBO_W:0]                combo_sum;
    logic [COMBO_W-1:0]              combo_play;
    logic                            found;

    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            zone[l] = |tracks_q[l][TRACK_LEN-1 -: WINDOW];
        end
    end

    // Judge presses, then shift the already-cleared tracks so a same-cycle hit never exits.
    always_comb begin
        press     = bus.keys & ~keys_q;
        cleared   = tracks_q;
        shifted   = tracks_q;
        hit       = '0;
        bad       = '0;
        exit_miss = '0;
        hit_cnt   = '0;
        bad_cnt   = '0;
        found     = 1'b0;
        for (int l = 0; l < int'(LANES); l++) begin
            hit[l] = press[l] & zone[l];
            bad[l] = press[l] & ~zone[l];
            found  = 1'b0;
            for (int p = int'(TRACK_LEN) - 1; p >= int'(WIN_LO); p--) begin
                if (hit[l] && !found && cleared[l][p]) begin
                    cleared[l][p] = 1'b0;
                    found         = 1'b1;
                end
            end
            if (bus.step) begin
                exit_miss[l] = cleared[l][TRACK_LEN-1];
                shifted[l]   = {cleared[l][TRACK_LEN-2:0], 1'b0};
            end else begin
                shifted[l]   = cleared[l];
            end
            if (hit[l]) hit_cnt = hit_cnt + CNT_W'(1);
            if (bad[l]) bad_cnt = bad_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        score_sum  = $signed({2'b00, score_q}) + $signed(SUM_W'(hit_cnt))
                   - $signed(SUM_W'(bad_cnt));
        combo_sum  = {1'b0, combo_q} + (COMBO_W + 1)'(hit_cnt);
        combo_play = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    end

    always_comb begin
        tracks_d     = tracks_q;
        score_d      = score_q;
        combo_d      = combo_q;
        max_combo_d  = max_combo_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        if (bus.load) begin
            tracks_d    = bus.load_notes;
            score_d     = '0;
            combo_d     = '0;
            max_combo_d = '0;
        end else if (state_q == StPlay) begin
            tracks_d     = shifted;
            hit_pulse_d  = |hit;
            miss_pulse_d = |bad | |exit_miss;
            if (score_sum[SUM_W-1]) begin
                score_d = '0;
            end else if (score_sum[SCORE_W]) begin
                score_d = '1;
            end else begin
                score_d = score_sum[SCORE_W-1:0];
            end
            combo_d     = miss_pulse_d ? '0 : combo_play;
            max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tracks_q     <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            max_combo_q  <= '0;
            keys_q       <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            tracks_q     <= tracks_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            max_combo_q  <= max_combo_d;
            keys_q       <= bus.keys;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.load) state_d = StPlay;
            StPlay:  if (!bus.load && tracks_d == '0) state_d = StDone;
            StDone:  if (bus.load) state_d = StPlay;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.playing = (state_q == StPlay);
        bus.done    = (state_q == StDone);
    end

    assign bus.tracks     = tracks_q;
    assign bus.hit_zone   = zone;
    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_combo_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
endmodule

// File: doc/note_judge_engine.md
# note_judge_engine

Parametrised multi-lane note tracker and judge for the rhythm game datapath. It holds one scrolling note track per lane and advances the tracks on a song-tempo step pulse. It judges player key presses against a configurable hit window and maintains score, combo and max-combo. It replaces the fixed three-lane note storage, player control and score counter trio, and feeds the HEX score display and the square animation.

## Interface
- LANES, default 3: number of note lanes (lane 2 = red, 1 = yellow, 0 = blue).
- TRACK_LEN, default 27: positions per track; index TRACK_LEN-1 is the judgement line.
- WINDOW, default 1: hit-zone depth, counted from the judgement line, 1..TRACK_LEN.
- SCORE_W, default 8: score width.
- COMBO_W, default 8: combo and max-combo width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse that loads the tracks and starts play.
- load_notes  in  LANES*TRACK_LEN  initial tracks; lane i occupies bits [i*TRACK_LEN +: TRACK_LEN].
- step  in  1  one-cycle tempo pulse that advances all tracks by one position.
- keys  in  LANES  active-high key levels, already inverted and synchronised.
- tracks  out  LANES*TRACK_LEN  current track contents, for animation.
- hit_zone  out  LANES  per lane: any note inside the hit window.
- score  out  SCORE_W  saturating score.
- combo  out  COMBO_W  current consecutive-hit count, saturating.
- max_combo  out  COMBO_W  highest combo reached since load.
- hit_pulse  out  1  one cycle high: at least one hit judged this cycle.
- miss_pulse  out  1  one cycle high: at least one miss event this cycle.
- playing  out  1  FSM in PLAY.
- done  out  1  FSM in DONE.

## Operation
- FSM states:
  - IDLE after reset. `load` → PLAY.
  - PLAY → DONE when all tracks are zero after the cycle's update.
  - DONE: `load` → PLAY.
  - `reset` from any state → IDLE.
- In IDLE and DONE, `step` and `keys` are ignored; only edge-detect registers update.
- Key edge: `press[i] = keys[i] & ~keys_q[i]`. `keys_q` updates every cycle in every state. A held key produces exactly one press.
- Per lane, in PLAY:
  - press with a note in the hit zone → hit. Clear the highest-index set bit in the window.
  - press with no note in the hit zone → bad press.
- Step, in PLAY: each lane shifts toward the MSB and bit 0 fills with 0. A set bit at TRACK_LEN-1 before the shift → exit miss.
- Same-cycle ordering:
  1. Hit clears are applied first.
  2. The shift is then applied to the cleared track.
  - A note hit in the same cycle it would exit is a hit, never a miss.
- Score: `next = score + hits - bad_presses`. Compute at SCORE_W+2 bits signed, then clamp to 0..2^SCORE_W-1. Exit misses do not change score.
- Combo:
  - any miss event (bad press or exit) this cycle → combo = 0, even if hits also occurred;
  - otherwise combo += hits, saturating at 2^COMBO_W-1.
  - max_combo = max(max_combo, next combo).
- `load` has priority over step and keys in the same cycle:
  - tracks ← load_notes;
  - score, combo, max_combo, hit_pulse, miss_pulse ← 0;
  - state ← PLAY. If load_notes is all zero, state goes to DONE on the next cycle.
- Reset values:
  - tracks, score, combo, max_combo, keys_q, hit_pulse, miss_pulse = 0;
  - state = IDLE (playing = 0, done = 0);
  - hit_zone = 0 (tracks are 0).

## Timing
- All outputs are registered except hit_zone, which is combinational from the `tracks` register.
- Latency: key rise sampled at clock edge k → score, combo and pulses updated at edge k, visible in cycle k+1. Same for step → tracks.
- Pulses last exactly one cycle and coincide with the score and combo update.
- A reset asserted mid-play takes effect on the next edge and overrides load.
- Throughput: step and presses are accepted every cycle; no backpressure.

## Test plan
- Reset, then load lane0 = bit 26 only, WINDOW=1. Press key0 (0→1) → next cycle score=1, combo=1, hit_pulse=1, tracks=0, then done=1.
- Load lane2 = bit 26, no press, pulse step → miss_pulse=1, combo=0, score unchanged, lane2 track=0.
- Press key1 with empty lane1 while score=0 → score stays 0 (clamp), combo=0, miss_pulse=1. Then hold key1 10 cycles → no further events.
- WINDOW=2, lane0 bits 26 and 25 set, press key0 and step in the same cycle → hit (bit 26 cleared), no exit miss, bit 25 moves to 26.
- Lanes 0 and 1 have notes in zone, lane 2 empty, press all three same cycle at score=5, combo=3 → score=6, combo=0, max_combo=3, both pulses=1.
- SCORE_W=8: 256 consecutive hits from score 250 → score saturates at 255. COMBO_W=8 combo saturates at 255. Then load → all counters 0, playing=1.
